parking_slot_allocator: RTL and testbench

- Sequential front end of the parking controller. Tracks which of the 8 slots are free, admits cars at the entry gate and releases slots at the exit.
- Drives the 8-bit slot_free vector (bit=1 means slot free) straight into parking_capacity_counter's new_capacity input, which derives empty/parked.
- Contains sensor synchronisers, an entry-gate FSM, lowest-free-slot allocation and exit validation.

---
 rtl/parking_slot_allocator_pkg.sv | 24 ++
 rtl/parking_slot_allocator_sync_edge.sv | 31 +++
 rtl/parking_slot_allocator.sv | 189 ++++++++++++++++++
 tb/tb_parking_slot_allocator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_slot_allocator_pkg.sv
// Shared constants, gate FSM encoding and slot-mask helper for the
// parking slot allocator.
package parking_slot_allocator_pkg;

  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_IDX_W = 3;
  localparam int GATE_CNT_W = 8;

  // Entry gate FSM encoding; 2'd3 is unused and recovers to GATE_IDLE.
  typedef enum logic [1:0] {
    GATE_IDLE  = 2'd0,
    GATE_OPEN  = 2'd1,
    GATE_CLEAR = 2'd2
  } gate_state_e;

  // One-hot mask with only bit idx set.
  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [SLOT_IDX_W-1:0] idx);
    logic [NUM_SLOTS-1:0] m;
    m      = {NUM_SLOTS{1'b0}};
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/parking_slot_allocator_sync_edge.sv
// Two-flop synchroniser for an asynchronous sensor level plus a
// rising-edge detector built from a third delay flop.
module park_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Shift the sensor through the synchroniser and the edge-delay flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign level = s2_r;
  assign rise  = s2_r & ~s3_r;

endmodule

// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: tracks free slots, admits cars through the
// entry gate (lowest free slot first) and validates departures.
// NUM_SLOTS must stay 8 to match the downstream capacity counter.
module parking_slot_allocator
  import parking_slot_allocator_pkg::*;
#(
  parameter int GATE_OPEN_CYCLES = 4,
  parameter int NUM_SLOTS        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  entry_req,
  input  logic                  exit_req,
  input  logic [SLOT_IDX_W-1:0] exit_slot,
  output logic [NUM_SLOTS-1:0]  slot_free,
  output logic                  entry_gate,
  output logic [SLOT_IDX_W-1:0] entry_slot,
  output logic                  entry_ok,
  output logic                  entry_wait,
  output logic                  exit_ok,
  output logic                  exit_err,
  output logic                  full
);

  localparam logic [GATE_CNT_W-1:0] GATE_LOAD = GATE_CNT_W'(GATE_OPEN_CYCLES);

  logic                  entry_lvl_s;
  logic                  entry_rise_s;
  logic                  exit_lvl_s;
  logic                  exit_evt_s;
  logic                  unused_sync_s;

  logic [NUM_SLOTS-1:0]  slot_free_r;
  gate_state_e           state_r;
  logic [GATE_CNT_W-1:0] gate_cnt_r;
  logic                  entry_gate_r;
  logic [SLOT_IDX_W-1:0] entry_slot_r;
  logic                  entry_ok_r;
  logic                  exit_ok_r;
  logic                  exit_err_r;

  logic                  full_s;
  logic                  admit_s;
  logic [SLOT_IDX_W-1:0] alloc_idx_s;
  logic [NUM_SLOTS-1:0]  alloc_mask_s;
  logic [NUM_SLOTS-1:0]  free_mask_s;
  logic                  exit_valid_s;
  logic                  exit_bad_s;

  park_sync_edge u_entry_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (entry_req),
    .level    (entry_lvl_s),
    .rise     (entry_rise_s)
  );

  park_sync_edge u_exit_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (exit_req),
    .level    (exit_lvl_s),
    .rise     (exit_evt_s)
  );

  // The entry path works on the level and the exit path on the edge only.
  assign unused_sync_s = entry_rise_s ^ exit_lvl_s;

  assign full_s  = (slot_free_r == {NUM_SLOTS{1'b0}});
  assign admit_s = (state_r == GATE_IDLE) && entry_lvl_s && !full_s;

  // Lowest-index free slot; the value is only used when some slot is free.
  always_comb begin
    alloc_idx_s = 3'd0;
    casez (slot_free_r)
      8'b???????1: alloc_idx_s = 3'd0;
      8'b??????10: alloc_idx_s = 3'd1;
      8'b?????100: alloc_idx_s = 3'd2;
      8'b????1000: alloc_idx_s = 3'd3;
      8'b???10000: alloc_idx_s = 3'd4;
      8'b??100000: alloc_idx_s = 3'd5;
      8'b?1000000: alloc_idx_s = 3'd6;
      8'b10000000: alloc_idx_s = 3'd7;
      default:     alloc_idx_s = 3'd0;
    endcase
  end

  // Classify a departure: freeing an occupied slot is valid, anything else is an error.
  always_comb begin
    exit_valid_s = 1'b0;
    exit_bad_s   = 1'b0;
    if (exit_evt_s) begin
      exit_valid_s = ~slot_free_r[exit_slot];
      exit_bad_s   = slot_free_r[exit_slot];
    end else begin
      exit_valid_s = 1'b0;
      exit_bad_s   = 1'b0;
    end
  end

  // Per-cycle bit masks for the slot being taken and the slot being released.
  always_comb begin
    alloc_mask_s = {NUM_SLOTS{1'b0}};
    free_mask_s  = {NUM_SLOTS{1'b0}};
    if (admit_s) begin
      alloc_mask_s = slot_mask(alloc_idx_s);
    end else begin
      alloc_mask_s = {NUM_SLOTS{1'b0}};
    end
    if (exit_valid_s) begin
      free_mask_s = slot_mask(exit_slot);
    end else begin
      free_mask_s = {NUM_SLOTS{1'b0}};
    end
  end

  // Slot map: allocation and release can land together since they never hit the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_free_r <= {NUM_SLOTS{1'b1}};
    end else begin
      slot_free_r <= (slot_free_r & ~alloc_mask_s) | free_mask_s;
    end
  end

  // Registered one-cycle departure result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exit_ok_r  <= 1'b0;
      exit_err_r <= 1'b0;
    end else begin
      exit_ok_r  <= exit_valid_s;
      exit_err_r <= exit_bad_s;
    end
  end

  // Entry gate FSM: admit once, hold the gate open, then wait for the car to clear the sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= GATE_IDLE;
      gate_cnt_r   <= 8'd0;
      entry_gate_r <= 1'b0;
      entry_slot_r <= 3'd0;
      entry_ok_r   <= 1'b0;
    end else begin
      entry_ok_r <= 1'b0;
      case (state_r)
        GATE_IDLE: begin
          if (admit_s) begin
            entry_slot_r <= alloc_idx_s;
            entry_ok_r   <= 1'b1;
            entry_gate_r <= 1'b1;
            gate_cnt_r   <= GATE_LOAD;
            state_r      <= GATE_OPEN;
          end
        end
        GATE_OPEN: begin
          if (gate_cnt_r <= 8'd1) begin
            entry_gate_r <= 1'b0;
            gate_cnt_r   <= 8'd0;
            state_r      <= GATE_CLEAR;
          end else begin
            gate_cnt_r <= gate_cnt_r - 8'd1;
          end
        end
        GATE_CLEAR: begin
          if (!entry_lvl_s) begin
            state_r <= GATE_IDLE;
          end
        end
        default: begin
          state_r      <= GATE_IDLE;
          gate_cnt_r   <= 8'd0;
          entry_gate_r <= 1'b0;
        end
      endcase
    end
  end

  assign slot_free  = slot_free_r;
  assign entry_gate = entry_gate_r;
  assign entry_slot = entry_slot_r;
  assign entry_ok   = entry_ok_r;
  assign entry_wait = (state_r == GATE_IDLE) && entry_lvl_s && full_s;
  assign exit_ok    = exit_ok_r;
  assign exit_err   = exit_err_r;
  assign full       = full_s;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Directed self-checking bench for parking_slot_allocator.
module tb_parking_slot_allocator;

  logic       clk;
  logic       rst_n;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic [7:0] slot_free;
  logic       entry_gate;
  logic [2:0] entry_slot;
  logic       entry_ok;
  logic       entry_wait;
  logic       exit_ok;
  logic       exit_err;
  logic       full;

  int tests_run = 0;
  int tests_failed = 0;

  parking_slot_allocator #(.GATE_OPEN_CYCLES(4), .NUM_SLOTS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .exit_slot  (exit_slot),
    .slot_free  (slot_free),
    .entry_gate (entry_gate),
    .entry_slot (entry_slot),
    .entry_ok   (entry_ok),
    .entry_wait (entry_wait),
    .exit_ok    (exit_ok),
    .exit_err   (exit_err),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Admit one car and let the gate cycle complete.
  task automatic admit_one();
    int n;
    n = 0;
    entry_req = 1'b1;
    while (entry_ok !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    check_eq("admit_seen", {31'd0, entry_ok}, 32'd1);
    step(6);
    entry_req = 1'b0;
    step(4);
  endtask

  task automatic exit_one(input logic [2:0] s);
    exit_slot = s;
    step(3);
    exit_req = 1'b1;
    step(3);
    exit_req = 1'b0;
    step(2);
  endtask

  initial begin
    int gate_cycles;
    int ok_cnt;
    int gate_seen;
    logic [7:0] exp_free;

    rst_n     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = 3'd0;
    step(2);
    check_eq("rst_slot_free", {24'd0, slot_free}, 32'hFF);
    check_eq("rst_outputs", {25'd0, entry_gate, entry_slot, entry_ok, exit_ok, exit_err},
             32'd0);
    check_eq("rst_full_wait", {30'd0, full, entry_wait}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Test 1: single admission, gate width, only one admission per request.
    entry_req = 1'b1;
    step(2);
    check_eq("t1_e1_free", {24'd0, slot_free}, 32'hFF);
    check_eq("t1_e1_ok", {31'd0, entry_ok}, 32'd0);
    step(1);
    check_eq("t1_e2_free", {24'd0, slot_free}, 32'hFE);
    check_eq("t1_e2_ok", {31'd0, entry_ok}, 32'd1);
    check_eq("t1_e2_slot", {29'd0, entry_slot}, 32'd0);
    check_eq("t1_e2_gate", {31'd0, entry_gate}, 32'd1);
    gate_cycles = 1;
    ok_cnt = 1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      gate_cycles += int'(entry_gate);
      ok_cnt += int'(entry_ok);
    end
    check_eq("t1_gate_cycles", gate_cycles, 32'd4);
    check_eq("t1_ok_count", ok_cnt, 32'd1);
    check_eq("t1_free_hold", {24'd0, slot_free}, 32'hFE);
    entry_req = 1'b0;
    step(4);

    // Test 2: fill the lot one car at a time.
    for (int i = 1; i < 8; i++) begin
      admit_one();
      exp_free = 8'hFF;
      exp_free = exp_free << (i + 1);
      check_eq("t2_free", {24'd0, slot_free}, {24'd0, exp_free});
      check_eq("t2_slot", {29'd0, entry_slot}, i);
    end
    check_eq("t2_full", {31'd0, full}, 32'd1);

    // Ninth car waits.
    entry_req = 1'b1;
    gate_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      gate_seen += int'(entry_gate);
    end
    check_eq("t2_wait", {31'd0, entry_wait}, 32'd1);
    check_eq("t2_no_gate", gate_seen, 32'd0);
    check_eq("t2_free_full", {24'd0, slot_free}, 32'h00);

    // Test 3: departure from slot 5 lets the waiting car in.
    exit_slot = 3'd5;
    step(3);
    exit_req = 1'b1;
    step(2);
    check_eq("t3_e1_free", {24'd0, slot_free}, 32'h00);
    check_eq("t3_e1_exit_ok", {31'd0, exit_ok}, 32'd0);
    step(1);
    check_eq("t3_e2_free", {24'd0, slot_free}, 32'h20);
    check_eq("t3_e2_exit_ok", {31'd0, exit_ok}, 32'd1);
    check_eq("t3_e2_wait", {31'd0, entry_wait}, 32'd0);
    check_eq("t3_e2_entry_ok", {31'd0, entry_ok}, 32'd0);
    step(1);
    check_eq("t3_e3_free", {24'd0, slot_free}, 32'h00);
    check_eq("t3_e3_entry_ok", {31'd0, entry_ok}, 32'd1);
    check_eq("t3_e3_slot", {29'd0, entry_slot}, 32'd5);
    check_eq("t3_e3_exit_ok", {31'd0, exit_ok}, 32'd0);
    check_eq("t3_e3_wait", {31'd0, entry_wait}, 32'd0);
    exit_req = 1'b0;
    step(6);
    entry_req = 1'b0;
    step(4);

    // Test 4: departure from an already-free slot is rejected.
    do_reset();
    admit_one();
    check_eq("t4_pre_free", {24'd0, slot_free}, 32'hFE);
    exit_slot = 3'd3;
    step(3);
    exit_req = 1'b1;
    step(3);
    check_eq("t4_exit_err", {31'd0, exit_err}, 32'd1);
    check_eq("t4_exit_ok", {31'd0, exit_ok}, 32'd0);
    check_eq("t4_free", {24'd0, slot_free}, 32'hFE);
    step(1);
    check_eq("t4_err_pulse", {31'd0, exit_err}, 32'd0);
    exit_req = 1'b0;
    step(3);

    // Test 5: admission and departure in the same cycle.
    admit_one();
    admit_one();
    admit_one();
    check_eq("t5_pre_free", {24'd0, slot_free}, 32'hF0);
    exit_slot = 3'd0;
    step(3);
    entry_req = 1'b1;
    exit_req = 1'b1;
    step(3);
    check_eq("t5_free", {24'd0, slot_free}, 32'hE1);
    check_eq("t5_slot", {29'd0, entry_slot}, 32'd4);
    check_eq("t5_ok_pair", {30'd0, entry_ok, exit_ok}, 32'd3);
    exit_req = 1'b0;
    step(6);
    entry_req = 1'b0;
    step(4);

    // Test 6: asynchronous reset while the gate is open at 8'h0F.
    do_reset();
    for (int i = 0; i < 8; i++) admit_one();
    for (int i = 0; i < 4; i++) exit_one(i[2:0]);
    check_eq("t6_pre_free", {24'd0, slot_free}, 32'h0F);
    exit_slot = 3'd0;
    step(3);
    entry_req = 1'b1;
    step(1);
    exit_req = 1'b1;
    step(2);
    check_eq("t6_admit_free", {24'd0, slot_free}, 32'h0E);
    check_eq("t6_gate_open", {31'd0, entry_gate}, 32'd1);
    step(1);
    check_eq("t6_open_free", {24'd0, slot_free}, 32'h0F);
    check_eq("t6_still_open", {31'd0, entry_gate}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_free", {24'd0, slot_free}, 32'hFF);
    check_eq("t6_rst_gate", {31'd0, entry_gate}, 32'd0);
    check_eq("t6_rst_pulses", {29'd0, entry_ok, exit_ok, exit_err}, 32'd0);
    entry_req = 1'b0;
    exit_req = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    check_eq("t6_post_free", {24'd0, slot_free}, 32'hFF);
    check_eq("t6_post_gate", {31'd0, entry_gate}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
